find_min_16_feeder: RTL

Frame collector and launcher for the 16-way pipelined minimum finder. It accepts signed samples one per handshake and packs them into a 16-slot flat vector. Short frames are padded with the most-positive value. It then pulses the finder's start strobe, waits for the finder's result, and presents index, value and sample count to the downstream consumer over a valid/ready handshake.

---
 rtl/find_min_16_feeder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/find_min_16_feeder.sv
// Frame collector and launcher for the 16-way pipelined minimum finder.
// Optional watchdog on the finder result: FIND_MIN_FEEDER_TIMEOUT_EN.
module find_min_16_feeder #(
  parameter int DATA_WIDTH = 48,
  parameter int TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_last,
  output logic                     start_find,
  output logic [16*DATA_WIDTH-1:0] data_in_flat,
  input  logic [DATA_WIDTH-1:0]    fm_min_val,
  input  logic [3:0]               fm_min_idx,
  input  logic                     fm_valid_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_WIDTH-1:0]    res_val,
  output logic [3:0]               res_idx,
  output logic [4:0]               res_count,
  output logic                     res_pad_hit,
  output logic                     res_err
);

  localparam logic [DATA_WIDTH-1:0] PAD = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_LAUNCH,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t     state_reg, state_next;
  logic [4:0] count_reg;
  logic       in_ready_reg, start_find_reg, res_valid_reg;
  logic [DATA_WIDTH-1:0] res_val_reg;
  logic [3:0] res_idx_reg;
  logic [4:0] res_count_reg;
  logic       res_pad_hit_reg, res_err_reg;
  logic       accept, close_frame, fm_hit, timeout_hit;

  if (TIMEOUT < 5) begin : g_timeout_check
    $error("find_min_16_feeder: TIMEOUT must be at least 5");
  end

  assign accept      = in_ready_reg & in_valid;
  // The 16th sample closes the frame whether or not in_last is set.
  assign close_frame = accept & (in_last | (count_reg == 5'd15));
  assign fm_hit      = (state_reg == ST_WAIT) & fm_valid_out;

`ifdef FIND_MIN_FEEDER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wd_cnt_reg <= '0;
    else if (state_reg == ST_LAUNCH)
      wd_cnt_reg <= '0;
    else if (state_reg == ST_WAIT)
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
  end

  assign timeout_hit = (state_reg == ST_WAIT) & ~fm_valid_out &
                       (wd_cnt_reg == WD_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    state_next = ST_COLLECT;
      ST_COLLECT: if (close_frame) state_next = ST_LAUNCH;
      ST_LAUNCH:  state_next = ST_WAIT;
      ST_WAIT:    if (fm_hit || timeout_hit) state_next = ST_HOLD;
      ST_HOLD:    if (res_ready) state_next = ST_COLLECT;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      in_ready_reg   <= 1'b0;
      start_find_reg <= 1'b0;
      res_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      in_ready_reg   <= (state_next == ST_COLLECT);
      start_find_reg <= (state_next == ST_LAUNCH);
      res_valid_reg  <= (state_next == ST_HOLD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_reg <= '0;
    else if ((state_reg == ST_HOLD) && res_ready)
      count_reg <= '0;
    else if (accept)
      count_reg <= count_reg + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_val_reg     <= '0;
      res_idx_reg     <= '0;
      res_count_reg   <= '0;
      res_pad_hit_reg <= 1'b0;
      res_err_reg     <= 1'b0;
    end else if (fm_hit) begin
      res_val_reg     <= fm_min_val;
      res_idx_reg     <= fm_min_idx;
      res_count_reg   <= count_reg;
      res_pad_hit_reg <= ({1'b0, fm_min_idx} >= count_reg);
      res_err_reg     <= 1'b0;
    end else if (timeout_hit) begin
      res_val_reg     <= '0;
      res_idx_reg     <= '0;
      res_count_reg   <= count_reg;
      res_pad_hit_reg <= 1'b0;
      res_err_reg     <= 1'b1;
    end
  end

  // Slots only change in COLLECT, so the frame stays stable through LAUNCH/WAIT.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] slot_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          slot_reg <= '0;
        else if (accept) begin
          if (count_reg == 5'(gi))
            slot_reg <= in_data;
          else if (close_frame && (count_reg < 5'(gi)))
            slot_reg <= PAD;
        end
      end

      assign data_in_flat[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
    end
  endgenerate

  assign in_ready    = in_ready_reg;
  assign start_find  = start_find_reg;
  assign res_valid   = res_valid_reg;
  assign res_val     = res_val_reg;
  assign res_idx     = res_idx_reg;
  assign res_count   = res_count_reg;
  assign res_pad_hit = res_pad_hit_reg;
`ifdef FIND_MIN_FEEDER_TIMEOUT_EN
  assign res_err     = res_err_reg;
`else
  assign res_err     = 1'b0;
`endif

endmodule
